ahb_arbiter: RTL and testbench
==============================

AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  ADDR_W, 32, address width.
  DATA_W, 32, data width.
  DEFAULT_MASTER, 1, master parked on bus when no requests (1 = instruction fetch).
  MAX_HOLD, 16, max accepted transfers per tenure before forced handover.
REQ-002 Ports, one per line: name, direction, width, meaning.
  hclk  in  1  bus clock.
  hresetn  in  1  reset; one clock, reset asynchronous active-low.
  hbusreq_m  in  2  bus request per master (bit0 data port, bit1 instruction fetch).
  hlock_m  in  2  lock request per master.
  haddr_m0/haddr_m1  in  ADDR_W  master address.
  htrans_m0/htrans_m1  in  2  master transfer type.
  hwrite_m0/hwrite_m1  in  1  master write.
  hsize_m0/hsize_m1  in  3  master size.
  hwdata_m0/hwdata_m1  in  DATA_W  master write data.
  hready  in  1  selected-slave ready from the response mux.
  hgrant_m  out  2  one-hot grant.
  hmaster  out  1  address-phase owner.
  hmaster_d  out  1  data-phase owner.
  hmastlock  out  1  owner lock, address phase.
  haddr/htrans/hwrite/hsize  out  ADDR_W/2/1/3  muxed address-phase signals, to the decoder and slaves.
  hwdata  out  DATA_W  muxed write data.

Function
REQ-003 hgrant_m, hmaster, hmastlock registered; address-phase outputs combinational mux selected by hmaster.
REQ-004 hwdata selected by hmaster_d; hmaster_d <= hmaster on every hclk edge with hready=1, held otherwise.
REQ-005 Arbitration point: hready=1 and owner htrans not SEQ and not BUSY; no grant change at any other cycle.
REQ-006 FSM states PARK, OWN; PARK = DEFAULT_MASTER granted with no request pending.
REQ-007 PARK -> OWN at an arbitration point with any hbusreq_m set; winner by round-robin.
REQ-008 OWN, owner request held and (lock set or no other request): keep grant.
REQ-009 OWN, owner request dropped: grant other master if requesting, else -> PARK.
REQ-010 Round-robin: on simultaneous requests, the master not granted last wins; pointer updates on each grant change.
REQ-011 Hold counter, 5 bits: +1 per owner NONSEQ/SEQ accepted (hready=1); cleared on grant change; saturates at MAX_HOLD.
REQ-012 Counter = MAX_HOLD, other master requesting, owner hlock=0: handover at next arbitration point.
REQ-013 Owner hlock=1: no forced handover, counter saturated; hmastlock = owner hlock registered with grant.
REQ-014 hready=0: grant, hmaster, hmaster_d, counter, pointer all frozen.
REQ-015 Grant change takes effect one cycle after the arbitration point; hgrant_m always exactly one-hot.

Reset
REQ-016 Asynchronous on hresetn=0, mid-transfer included: hgrant_m = one-hot DEFAULT_MASTER, hmaster = hmaster_d = DEFAULT_MASTER, hmastlock=0, counter=0, RR pointer=0, state PARK.
REQ-017 First grant change no earlier than the second rising hclk after hresetn deasserts.

Structure
REQ-018 Package ahb_pkg: htrans encodings (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11), master-id type, MAX_HOLD default, FSM state enum.
REQ-019 One sub-module, ahb_arb_rr: 2-way round-robin picker (requests, pointer -> winner).

Verification
REQ-020 Reset, no requests -> hgrant_m=2'b10, hmaster=1, htrans mirrors M1.
REQ-021 M0 and M1 both request from PARK, pointer=0 -> M0 granted; M0 releases -> M1 granted next cycle; hmaster_d follows hmaster one hready cycle later.
REQ-022 M1 owns and issues 16 NONSEQ with hready=1 while M0 requests -> grant to M0 after the 16th; with hlock_m[1]=1 -> M1 keeps grant.
REQ-023 Owner htrans=SEQ, hready held 0 for 3 cycles, other master requesting -> no grant change until hready=1 and htrans=IDLE/NONSEQ.
REQ-024 M0 write to 0xB000_0010, data 0xDEAD_BEEF, grant moves to M1 in the same cycle -> hwdata=0xDEAD_BEEF in M0's data phase (hmaster_d=0).
REQ-025 hresetn pulled low mid-burst -> all outputs at REQ-016 values without waiting for an hclk edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, master id type and arbiter state enum for the
// two-master AHB-Lite arbiter.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // bit0 = data port master, bit1 = instruction fetch master
  typedef logic mid_t;

  localparam int AHB_MAX_HOLD = 16;

  typedef enum logic {
    PARK = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ahb_arb_rr.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes
// to the master named by the pointer.
module ahb_arb_rr
  import ahb_pkg::*;
(
  input  logic [1:0] req,
  input  mid_t       ptr,
  output mid_t       win
);

  always_comb begin
    win = ptr;
    if (req[0] && !req[1]) win = 1'b0;
    else if (req[1] && !req[0]) win = 1'b1;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB arbiter with bus parking, round-robin tie break, a per-tenure
// transfer limit and lock support; muxes address and write-data phases.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DEFAULT_MASTER = 1,
  parameter int MAX_HOLD       = AHB_MAX_HOLD
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic [1:0]        hbusreq_m,
  input  logic [1:0]        hlock_m,
  input  logic [ADDR_W-1:0] haddr_m0,
  input  logic [ADDR_W-1:0] haddr_m1,
  input  logic [1:0]        htrans_m0,
  input  logic [1:0]        htrans_m1,
  input  logic              hwrite_m0,
  input  logic              hwrite_m1,
  input  logic [2:0]        hsize_m0,
  input  logic [2:0]        hsize_m1,
  input  logic [DATA_W-1:0] hwdata_m0,
  input  logic [DATA_W-1:0] hwdata_m1,
  input  logic              hready,
  output logic [1:0]        hgrant_m,
  output logic              hmaster,
  output logic              hmaster_d,
  output logic              hmastlock,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [DATA_W-1:0] hwdata
);

  localparam mid_t       DEF_M    = mid_t'(DEFAULT_MASTER);
  localparam logic [4:0] HOLD_MAX = 5'(MAX_HOLD);

  arb_state_e state, state_nxt;
  mid_t       owner_nxt, ptr, ptr_nxt, rr_win, other;
  logic [4:0] cnt, cnt_nxt, cnt_acc;
  logic       lock_nxt, armed, start, arb_pt, xfer;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= HOLD_MAX) ? HOLD_MAX : v + 5'd1;
  endfunction

  assign haddr  = hmaster   ? haddr_m1  : haddr_m0;
  assign htrans = hmaster   ? htrans_m1 : htrans_m0;
  assign hwrite = hmaster   ? hwrite_m1 : hwrite_m0;
  assign hsize  = hmaster   ? hsize_m1  : hsize_m0;
  assign hwdata = hmaster_d ? hwdata_m1 : hwdata_m0;

  assign other  = ~hmaster;
  assign xfer   = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  // armed keeps the first edge after reset release decision-free
  assign arb_pt = armed && hready && (htrans != HTRANS_SEQ) && (htrans != HTRANS_BUSY);

  ahb_arb_rr u_rr (
    .req (hbusreq_m),
    .ptr (ptr),
    .win (rr_win)
  );

  always_comb begin
    state_nxt = state;
    owner_nxt = hmaster;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    lock_nxt  = hmastlock;
    start     = 1'b0;
    cnt_acc   = xfer ? sat_inc(cnt) : cnt;
    if (hready) begin
      if (arb_pt) begin
        case (state)
          PARK: begin
            if (|hbusreq_m) begin
              state_nxt = OWN;
              owner_nxt = rr_win;
              start     = 1'b1;
            end
          end
          OWN: begin
            if (hbusreq_m[hmaster]) begin
              // the transfer accepted this cycle counts toward the limit
              if (hbusreq_m[other] && !hlock_m[hmaster] && cnt_acc == HOLD_MAX) begin
                owner_nxt = other;
                start     = 1'b1;
              end
            end else if (hbusreq_m[other]) begin
              owner_nxt = other;
              start     = 1'b1;
            end else begin
              state_nxt = PARK;
              owner_nxt = DEF_M;
            end
          end
          default: ;
        endcase
      end
      cnt_nxt  = (state_nxt == OWN && !start) ? cnt_acc : 5'd0;
      if (start || owner_nxt != hmaster) ptr_nxt = ~owner_nxt;
      lock_nxt = (state_nxt == OWN) && hlock_m[owner_nxt];
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= PARK;
      hmaster   <= DEF_M;
      hmaster_d <= DEF_M;
      hgrant_m  <= {DEF_M, ~DEF_M};
      hmastlock <= 1'b0;
      ptr       <= 1'b0;
      cnt       <= 5'd0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hmaster   <= owner_nxt;
      hgrant_m  <= {owner_nxt, ~owner_nxt};
      hmastlock <= lock_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      armed     <= 1'b1;
      if (hready) hmaster_d <= hmaster;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a rule-level model.
module tb_ahb_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXH = 16;
  localparam int DEFM = 1;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic [1:0]    hbusreq_m = 2'b00, hlock_m = 2'b00;
  logic [AW-1:0] haddr_m0 = '0, haddr_m1 = '0;
  logic [1:0]    htrans_m0 = 2'b00, htrans_m1 = 2'b00;
  logic          hwrite_m0 = 1'b0, hwrite_m1 = 1'b0;
  logic [2:0]    hsize_m0 = 3'd0, hsize_m1 = 3'd0;
  logic [DW-1:0] hwdata_m0 = '0, hwdata_m1 = '0;
  logic          hready = 1'b1;

  logic [1:0]    hgrant_m;
  logic          hmaster, hmaster_d, hmastlock;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [DW-1:0] hwdata;

  int checks = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq_m(hbusreq_m), .hlock_m(hlock_m),
    .haddr_m0(haddr_m0), .haddr_m1(haddr_m1), .htrans_m0(htrans_m0), .htrans_m1(htrans_m1),
    .hwrite_m0(hwrite_m0), .hwrite_m1(hwrite_m1), .hsize_m0(hsize_m0), .hsize_m1(hsize_m1),
    .hwdata_m0(hwdata_m0), .hwdata_m1(hwdata_m1), .hready(hready),
    .hgrant_m(hgrant_m), .hmaster(hmaster), .hmaster_d(hmaster_d), .hmastlock(hmastlock),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge hclk);
    #2;
  endtask

  // Reference model: who owns the bus, whether it is parked, who wins a tie,
  // how many transfers the current tenure has had, and the data-phase owner.
  int m_owner = DEFM, m_parked = 1, m_pref = 0, m_count = 0, m_lock = 0;
  int m_md = DEFM, m_edges = 0;

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      m_owner = DEFM; m_parked = 1; m_pref = 0; m_count = 0;
      m_lock = 0; m_md = DEFM; m_edges = 0;
    end else begin
      if (hready) begin
        int tr, oth, nxt, tenure, park, xfer, acc;
        tr   = (m_owner == 1) ? int'(htrans_m1) : int'(htrans_m0);
        oth  = 1 - m_owner;
        xfer = (tr == 2 || tr == 3) ? 1 : 0;
        acc  = (m_count + xfer > MAXH) ? MAXH : m_count + xfer;
        nxt = m_owner; park = m_parked; tenure = 0;
        if (m_edges > 0 && tr != 3 && tr != 1) begin
          if (m_parked != 0) begin
            if (hbusreq_m != 2'b00) begin
              park = 0; tenure = 1;
              nxt = (hbusreq_m == 2'b11) ? m_pref : (hbusreq_m[1] ? 1 : 0);
            end
          end else if (hbusreq_m[m_owner]) begin
            if (hbusreq_m[oth] && !hlock_m[m_owner] && acc == MAXH) begin
              nxt = oth; tenure = 1;
            end
          end else if (hbusreq_m[oth]) begin
            nxt = oth; tenure = 1;
          end else begin
            park = 1; nxt = DEFM;
          end
        end
        m_count = (park != 0 || tenure != 0) ? 0 : acc;
        if (tenure != 0 || nxt != m_owner) m_pref = 1 - nxt;
        m_md    = m_owner;
        m_lock  = (park == 0 && hlock_m[nxt]) ? 1 : 0;
        m_owner = nxt;
        m_parked = park;
      end
      m_edges++;
    end
  end

  always @(negedge hclk) begin
    logic [1:0] eg;
    logic [AW+5:0] eap;
    eg  = (m_owner == 1) ? 2'b10 : 2'b01;
    eap = (m_owner == 1) ? {haddr_m1, htrans_m1, hwrite_m1, hsize_m1}
                         : {haddr_m0, htrans_m0, hwrite_m0, hsize_m0};
    chk("ctrl", {hgrant_m, hmaster, hmaster_d, hmastlock},
        {eg, m_owner == 1, m_md == 1, m_lock == 1});
    chk("aphase", {haddr, htrans, hwrite, hsize}, eap);
    chk("hwdata", hwdata, (m_md == 1) ? hwdata_m1 : hwdata_m0);
  end

  initial begin
    int n;
    // reset state, parked on M1, no early grant change after release
    htrans_m1 = 2'b10; htrans_m0 = 2'b00; hbusreq_m = 2'b01;
    #12;
    chk("rst_grant", hgrant_m, 2'b10);
    chk("rst_owners", {hmaster, hmaster_d, hmastlock}, 3'b110);
    chk("rst_htrans_m1", htrans, 2'b10);
    #11 hresetn = 1'b1;
    cyc(1);
    chk("rst_no_early", hmaster, 1'b1);
    cyc(1);
    chk("rst_second_edge", hmaster, 1'b0);

    // tie from park with pointer 0, then release
    hbusreq_m = 2'b00; htrans_m1 = 2'b00; hresetn = 1'b0;
    #10 hresetn = 1'b1;
    cyc(2);
    hbusreq_m = 2'b11;
    cyc(1);
    chk("rr_tie_m0", {hgrant_m, hmaster}, 3'b010);
    hbusreq_m = 2'b10;
    cyc(1);
    chk("release_m1", {hgrant_m, hmaster, hmaster_d}, 4'b1010);
    cyc(1);
    chk("hmaster_d_follow", hmaster_d, 1'b1);

    // M0 write while the grant moves to M1
    hbusreq_m = 2'b01;
    cyc(1);
    chk("m0_owns", hmaster, 1'b0);
    htrans_m0 = 2'b10; haddr_m0 = 32'hB000_0010; hwrite_m0 = 1'b1; hbusreq_m = 2'b10;
    #1 chk("wr_addr", {haddr, hwrite}, {32'hB000_0010, 1'b1});
    cyc(1);
    htrans_m0 = 2'b00; hwrite_m0 = 1'b0; hwdata_m0 = 32'hDEAD_BEEF; hwdata_m1 = 32'h1234_5678;
    #1 chk("wr_data_phase", {hmaster, hmaster_d, hwdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});

    // M1 forced off after 16 accepted NONSEQ while M0 waits
    hbusreq_m = 2'b11; htrans_m1 = 2'b10; hlock_m = 2'b00;
    #1 n = 0;
    while (hmaster == 1'b1 && n < 40) begin
      n++;
      cyc(1);
    end
    chk("hold_limit", n, 16);

    // with lock the owner keeps the bus past the limit
    hbusreq_m = 2'b10; htrans_m1 = 2'b00;
    cyc(1);
    hlock_m = 2'b10; hbusreq_m = 2'b11; htrans_m1 = 2'b10;
    cyc(30);
    chk("lock_keep", {hmaster, hmastlock}, 2'b11);

    // stall inside a burst: no handover until an IDLE/NONSEQ with hready
    hlock_m = 2'b00; htrans_m1 = 2'b11; hready = 1'b0;
    cyc(3);
    chk("stall_hold", {hmaster, hgrant_m}, 3'b110);
    hready = 1'b1;
    cyc(1);
    chk("seq_no_arb", hmaster, 1'b1);
    htrans_m1 = 2'b00;
    cyc(1);
    chk("idle_handover", {hmaster, hgrant_m}, 3'b001);

    // asynchronous reset in the middle of a burst
    hbusreq_m = 2'b01; htrans_m0 = 2'b10;
    cyc(1);
    htrans_m0 = 2'b11;
    #1 hresetn = 1'b0;
    #1 chk("async_rst", {hgrant_m, hmaster, hmaster_d, hmastlock}, 5'b10110);
    @(posedge hclk);
    #2 hresetn = 1'b1; htrans_m0 = 2'b00; hbusreq_m = 2'b00;
    cyc(2);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int t0, t1;
      if (i == 1500) hresetn = 1'b0;
      if (i == 1502) hresetn = 1'b1;
      if ($urandom_range(0, 4) == 0) hbusreq_m = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) hlock_m = 2'($urandom_range(0, 3));
      t0 = $urandom_range(0, 7);
      t1 = $urandom_range(0, 7);
      htrans_m0 = (t0 < 2) ? 2'(t0) : ((t0 < 5) ? 2'b10 : 2'b11);
      htrans_m1 = (t1 < 2) ? 2'(t1) : ((t1 < 5) ? 2'b10 : 2'b11);
      hready    = ($urandom_range(0, 3) != 0);
      haddr_m0  = $urandom;  haddr_m1  = $urandom;
      hwrite_m0 = 1'($urandom); hwrite_m1 = 1'($urandom);
      hsize_m0  = 3'($urandom); hsize_m1  = 3'($urandom);
      hwdata_m0 = $urandom;  hwdata_m1 = $urandom;
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
